// File: rtl/seq_det_ctrl_if.sv
// Control and serial-data bundle for seq_det_ctrl.
// The master side drives configuration, run control and serial data; the slave side reports status.
interface seq_det_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_load;
    logic [3:0]       cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             inp;
    logic             inp_valid;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;
    logic             timeout;

    modport master (
        output cfg_load, cfg_pattern, cfg_overlap, cfg_target,
        output start, abort, inp, inp_valid,
        input  out, match_cnt, busy, done, timeout
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_overlap, cfg_target,
        input  start, abort, inp, inp_valid,
        output out, match_cnt, busy, done, timeout
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Serial 4-bit pattern detector with match counting and run control.
// Optional idle-input timeout enabled by defining SEQ_DET_CTRL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; cfg_load updates shadow config
// ARMED | sampling inp, counting matches
// DONE  | target reached or timed out; inp ignored until start
module seq_det_ctrl #(
    parameter int CNT_W  = 8,
    parameter int TO_CYC = 16
) (
    input  logic         clck,
    input  logic         rst,
    seq_det_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nx;
    logic [3:0]       hist;
    logic [2:0]       fill;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    logic [3:0]       sh_pattern;
    logic             sh_overlap;
    logic [CNT_W-1:0] sh_target;

    logic [3:0]       hist_nx;
    logic [2:0]       fill_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             match;
    logic             to_hit;
    logic             arm;

    if (TO_CYC < 1) begin : g_bad_to_cyc
        $error("seq_det_ctrl: TO_CYC must be at least 1");
    end

    assign hist_nx = {hist[2:0], bus.inp};
    assign fill_nx = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign match   = (state == ARMED) && bus.inp_valid &&
                     (hist_nx == sh_pattern) && (fill_nx == 3'd4);
    assign arm     = (state == IDLE) && bus.start && !bus.abort;

    always_ff @(posedge clck) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (arm) state_nx = ARMED;
            ARMED: begin
                if (bus.abort)
                    state_nx = IDLE;
                else if (match && (sh_target != '0) && (cnt_inc == sh_target))
                    state_nx = DONE;
                else if (to_hit)
                    state_nx = DONE;
            end
            DONE:  if (bus.abort || bus.start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == ARMED);
        bus.done = (state == DONE);
    end

    // Abort suppresses both the history update and the match pulse.
    always_ff @(posedge clck) begin
        if (rst) begin
            hist       <= 4'b0000;
            fill       <= 3'd0;
            cnt        <= '0;
            out_q      <= 1'b0;
            sh_pattern <= 4'b1010;
            sh_overlap <= 1'b1;
            sh_target  <= '0;
        end else begin
            out_q <= 1'b0;
            if (state == IDLE && bus.cfg_load) begin
                sh_pattern <= bus.cfg_pattern;
                sh_overlap <= bus.cfg_overlap;
                sh_target  <= bus.cfg_target;
            end
            if (arm) begin
                hist <= 4'b0000;
                fill <= 3'd0;
                cnt  <= '0;
            end else if (state == ARMED && !bus.abort && bus.inp_valid) begin
                hist <= hist_nx;
                fill <= (match && !sh_overlap) ? 3'd0 : fill_nx;
                if (match) begin
                    out_q <= 1'b1;
                    cnt   <= cnt_inc;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt;

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TO_CYC + 1);

    logic [TMR_W-1:0] tmr;
    logic             timeout_q;

    assign to_hit = (state == ARMED) && !bus.inp_valid && (tmr == TMR_W'(1));

    // Down-counter reloaded on arm and on every valid bit; terminal count 1.
    always_ff @(posedge clck) begin
        if (rst) begin
            tmr       <= TMR_W'(TO_CYC);
            timeout_q <= 1'b0;
        end else if (arm) begin
            tmr       <= TMR_W'(TO_CYC);
            timeout_q <= 1'b0;
        end else if (state == ARMED && !bus.abort) begin
            if (bus.inp_valid)
                tmr <= TMR_W'(TO_CYC);
            else if (to_hit)
                timeout_q <= 1'b1;
            else
                tmr <= tmr - 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of the match counter and target.
REQ-002 SHALL have parameter TO_CYC, default 16, the idle-input timeout in cycles (used only when SEQ_DET_CTRL_TIMEOUT_EN is defined).
REQ-003 SHALL have port clck, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port cfg_load, input, 1, which latches the cfg_* values when the block is in IDLE.
REQ-006 SHALL have port cfg_pattern, input, 4, the target bit sequence; bit 3 is the first serial bit.
REQ-007 SHALL have port cfg_overlap, input, 1: 1 selects overlapping detection, 0 selects non-overlapping.
REQ-008 SHALL have port cfg_target, input, CNT_W, the number of matches that ends the run; 0 means run indefinitely.
REQ-009 SHALL have port start, input, 1, which arms detection.
REQ-010 SHALL have port abort, input, 1, which forces an immediate return to IDLE.
REQ-011 SHALL have port inp, input, 1, the serial data bit.
REQ-012 SHALL have port inp_valid, input, 1, which qualifies inp.
REQ-013 SHALL have port out, output, 1, a one-cycle match pulse.
REQ-014 SHALL have port match_cnt, output, CNT_W, the matches counted in the current run.
REQ-015 SHALL have port busy, output, 1, high in the ARMED state.
REQ-016 SHALL have port done, output, 1, high in the DONE state.
REQ-017 SHALL have port timeout, output, 1, the sticky timeout flag.

Function
REQ-018 SHALL implement the states IDLE, ARMED and DONE.
REQ-019 SHALL, in IDLE, apply cfg_load by copying pattern, overlap and target into shadow registers; cfg_load SHALL be ignored outside IDLE.
REQ-020 SHALL, on IDLE with start=1, go to ARMED next cycle, clearing the history register, fill count and match_cnt; if cfg_load and start are high together, the new config SHALL be used.
REQ-021 SHALL, in ARMED with inp_valid=1, shift inp into a 4-bit history (LSB = newest) and increment the saturating fill count (0..4); cycles with inp_valid=0 SHALL leave the history unchanged.
REQ-022 SHALL declare a match when the updated history equals the shadow pattern and the updated fill count is 4.
REQ-023 SHALL make out a registered pulse, high for exactly one cycle on the cycle after the matching bit was sampled (latency 1).
REQ-024 SHALL, on a match in overlapping mode, keep the history and fill count so that suffix bits count toward the next match.
REQ-025 SHALL, on a match in non-overlapping mode, clear the fill count to 0 so that the next match needs 4 new valid bits.
REQ-026 SHALL increment match_cnt on each match, saturating at all-ones.
REQ-027 SHALL, when target is nonzero and the incremented match_cnt equals target, go to DONE in the same cycle out pulses.
REQ-028 SHALL hold done high in DONE and ignore inp; start SHALL return the block to IDLE while match_cnt and timeout are held until the next arm.
REQ-029 SHALL, on abort in any state, go to IDLE next cycle without changing match_cnt; abort SHALL take priority over start, a match and timeout.
REQ-030 SHALL treat start during ARMED as a no-op.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state IDLE, history 0, fill 0, match_cnt 0, out 0, timeout 0, shadow pattern 4'b1010, shadow overlap 1 and shadow target 0.
REQ-032 SHALL let rst take priority over all inputs, including mid-run, with no match pulse emitted in the reset cycle.

Configuration
REQ-033 SHALL, with SEQ_DET_CTRL_TIMEOUT_EN defined, count consecutive ARMED cycles with inp_valid=0, reload the counter on every valid bit, and on reaching TO_CYC set timeout=1 and go to DONE.
REQ-034 SHALL, without SEQ_DET_CTRL_TIMEOUT_EN, tie the timeout port to 0 and instantiate no timeout counter.

Verification
REQ-035 SHALL verify the default config (1010, overlap, target 0) with stream 1,0,1,0,1,0 valid every cycle -> out pulses after bits 4 and 6, match_cnt=2.
REQ-036 SHALL verify overlap=0 with the same stream -> a single pulse after bit 4, match_cnt=1.
REQ-037 SHALL verify pattern 1101, target 2, stream 1,1,0,1,1,0,1 -> pulses after bits 4 and 7, done=1, busy=0, and later bits ignored.
REQ-038 SHALL verify that inp_valid gaps of 3 cycles between each bit of 1010 still produce a match, with out high exactly 1 cycle.
REQ-039 SHALL verify that rst asserted after bits 1,0,1 followed by re-arm and bit 0 gives no match, with fill restarting from 0.
REQ-040 SHALL verify that, with SEQ_DET_CTRL_TIMEOUT_EN and TO_CYC=16, 16 idle ARMED cycles give timeout=1 and done=1; without the macro, timeout stays 0.
